// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
//
// This is a synchronously read instruction memory for the single-cycle RISC-V
// core. It sits between the PC register and the decoder.
//
// After reset, a clear sequencer writes NOP into every word, one word per
// cycle. The module then accepts fetches with a one-cycle latency. A
// programming port writes one word at a time. If a programming write and a
// fetch occur in the same cycle, the write wins and the fetch stalls.
//
// Fetch faults (misaligned or out-of-range) return NOP and report a cause.
//
// Optional build macro: INSTR_MEM_PARITY_EN
//   - Each stored word carries an even-parity bit.
//   - prog_perr_inject corrupts the stored parity bit on a write.
//   - A read with bad parity returns NOP with cause 2'b11.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high reset (restarts the clear)
//   fetch_req         fetch request
//   fetch_addr        byte address of the fetch (PC)
//   fetch_ready       fetch accepted this cycle if fetch_req is also high
//   instr_valid       one-cycle pulse: instr/fetch_fault/fault_cause are valid
//   instr             fetched instruction (NOP on a fault; holds when idle)
//   fetch_fault       the accepted fetch faulted
//   fault_cause       00 none, 01 misaligned, 10 out of range, 11 parity
//   prog_we           programming write strobe (ignored during clear)
//   prog_addr         word index to program
//   prog_data         word to program
//   prog_perr_inject  invert stored parity on this write (parity build only)
//   init_done         clear sequence has finished
// -----------------------------------------------------------------------------
module instr_mem_fetch #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 64,
    parameter int              AW    = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [AW-1:0]            fetch_addr,
    output logic                     fetch_ready,
    output logic                     instr_valid,
    output logic [XLEN-1:0]          instr,
    output logic                     fetch_fault,
    output logic [1:0]               fault_cause,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [XLEN-1:0]          prog_data,
    input  logic                     prog_perr_inject,
    output logic                     init_done
);

    localparam int IW = $clog2(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
    localparam int MW = XLEN + 1;
`else
    localparam int MW = XLEN;
`endif
    // First byte address past the end of the array.
    localparam logic [AW:0] LIMIT = (AW+1)'(4 * DEPTH);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] clr_idx_reg, clr_idx_next;

    // ------------------------------------------------------------------
    // Clear / ready FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            CLEAR: begin
                if (clr_idx_reg == IW'(DEPTH - 1)) begin
                    state_next   = READY;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + 1'b1;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    assign init_done   = (state_reg == READY);
    assign fetch_ready = (state_reg == READY) && !prog_we;

    // ------------------------------------------------------------------
    // Single write port shared by the clear sequencer and programming port.
    // ------------------------------------------------------------------
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx_reg;
`ifdef INSTR_MEM_PARITY_EN
        mem_wdata = {^NOP, NOP};
`else
        mem_wdata = NOP;
`endif
        if (!reset) begin
            if (state_reg == CLEAR) begin
                mem_we = 1'b1;
            end else if (prog_we) begin
                mem_we    = 1'b1;
                mem_waddr = prog_addr;
`ifdef INSTR_MEM_PARITY_EN
                mem_wdata = {(^prog_data) ^ prog_perr_inject, prog_data};
`else
                mem_wdata = prog_data;
`endif
            end
        end
    end

`ifndef INSTR_MEM_PARITY_EN
    // The parity-inject input has no function without parity storage.
    logic unused_perr_inject;
    assign unused_perr_inject = prog_perr_inject;
`endif

    // ------------------------------------------------------------------
    // Storage: registered read, no reset. A fetch is never accepted in a
    // cycle that also writes (clear or prog_we), so read-during-write
    // behaviour never matters.
    // ------------------------------------------------------------------
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] rdata_reg;

    logic          accept;
    logic [IW-1:0] rd_idx;
    logic [1:0]    addr_cause;

    assign accept = fetch_req && fetch_ready && !reset;
    assign rd_idx = fetch_addr[IW+1:2];

    always_comb begin
        addr_cause = 2'b00;
        if (fetch_addr[1:0] != 2'b00) begin
            addr_cause = 2'b01;
        end else if ({1'b0, fetch_addr} >= LIMIT) begin
            addr_cause = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rdata_reg <= mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    //
    // Address faults are resolved at accept time. The parity check runs on
    // the registered read data. force_nop_reg keeps instr at NOP after a
    // faulted fetch or a reset, until the next clean fetch.
    // ------------------------------------------------------------------
    logic       valid_reg;
    logic [1:0] addr_cause_reg;
    logic       force_nop_reg;
    logic       perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            addr_cause_reg <= 2'b00;
            force_nop_reg  <= 1'b1;
        end else begin
            valid_reg <= accept;
            if (accept) begin
                addr_cause_reg <= addr_cause;
                force_nop_reg  <= (addr_cause != 2'b00);
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    // Even parity over data+parity: any odd XOR is a mismatch.
    assign perr = !force_nop_reg && (^rdata_reg);
`else
    assign perr = 1'b0;
`endif

    assign instr_valid = valid_reg;
    assign instr       = (force_nop_reg || perr) ? NOP : rdata_reg[XLEN-1:0];

    always_comb begin
        fetch_fault = 1'b0;
        fault_cause = 2'b00;
        if (valid_reg) begin
            if (addr_cause_reg != 2'b00) begin
                fetch_fault = 1'b1;
                fault_cause = addr_cause_reg;
            end else if (perr) begin
                fetch_fault = 1'b1;
                fault_cause = 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
//
// Directed, self-checking bench for instr_mem_fetch with DEPTH=64.
//
// Inputs are driven 1 time unit after a rising edge. Outputs are checked
// 1 time unit after the edge whose effect they show. The parity steps are
// compiled only when INSTR_MEM_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_perr_inject;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    instr_mem_fetch #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .AW   (AW),
        .NOP  (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (fetch_ready),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .fetch_fault     (fetch_fault),
        .fault_cause     (fault_cause),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .prog_perr_inject(prog_perr_inject),
        .init_done       (init_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one fetch for exactly one edge, then check the result.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_instr, input logic exp_fault,
                         input logic [1:0] exp_cause);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, exp_fault});
        chk({tag, "_cause"}, {30'd0, fault_cause}, {30'd0, exp_cause});
    endtask

    task automatic prog(input logic [5:0] a, input logic [31:0] d, input logic inj);
        prog_we          = 1'b1;
        prog_addr        = a;
        prog_data        = d;
        prog_perr_inject = inj;
        step();
        prog_we          = 1'b0;
        prog_perr_inject = 1'b0;
        $display("prog word %0d = %h inject=%0d", a, d, inj);
    endtask

    // Release reset and run the clear. init_done must stay low through
    // edge DEPTH-2 and be high after edge DEPTH-1.
    task automatic run_clear(input string tag);
        reset = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) step();
        chk({tag, "_init_low"}, {31'd0, init_done}, 32'd0);
        step();
        chk({tag, "_init_high"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_ready_high"}, {31'd0, fetch_ready}, 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        fetch_req        = 1'b0;
        fetch_addr       = '0;
        prog_we          = 1'b0;
        prog_addr        = '0;
        prog_data        = '0;
        prog_perr_inject = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        chk("rst_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_init", {31'd0, init_done}, 32'd0);

        // ---------------- 1: clear sequence ----------------
        run_clear("clr1");
        fetch("f0", 32'h0, NOP, 1'b0, 2'b00);
        fetch("f4", 32'h4, NOP, 1'b0, 2'b00);
        fetch("ffc", 32'hFC, NOP, 1'b0, 2'b00);
        step();
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);

        // ---------------- 2: program and stream ----------------
        prog(6'd3, 32'h019806B3, 1'b0);
        fetch("p3", 32'hC, 32'h019806B3, 1'b0, 2'b00);
        prog(6'd0, 32'h00100093, 1'b0);
        prog(6'd1, 32'h00200113, 1'b0);
        prog(6'd2, 32'h00310193, 1'b0);
        fetch("s0", 32'h0, 32'h00100093, 1'b0, 2'b00);
        fetch("s1", 32'h4, 32'h00200113, 1'b0, 2'b00);
        fetch("s2", 32'h8, 32'h00310193, 1'b0, 2'b00);
        fetch("s3", 32'hC, 32'h019806B3, 1'b0, 2'b00);
        step();
        chk("hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("hold_instr", instr, 32'h019806B3);

        // ---------------- 3: faults ----------------
        fetch("mis6", 32'h6, NOP, 1'b1, 2'b01);
        fetch("oor100", 32'h100, NOP, 1'b1, 2'b10);
        fetch("mis102", 32'h102, NOP, 1'b1, 2'b01);
        fetch("oorbig", 32'h8000_0000, NOP, 1'b1, 2'b10);
        step();
        chk("fidle_valid", {31'd0, instr_valid}, 32'd0);
        chk("fidle_fault", {31'd0, fetch_fault}, 32'd0);
        chk("fidle_cause", {30'd0, fault_cause}, 32'd0);
        chk("fidle_instr", instr, NOP);
        fetch("after_fault", 32'h4, 32'h00200113, 1'b0, 2'b00);

        // ---------------- 4: write/fetch collision ----------------
        prog_we    = 1'b1;
        prog_addr  = 6'd7;
        prog_data  = 32'hDEADBEEF;
        fetch_req  = 1'b1;
        fetch_addr = 32'h1C;
        #1;
        chk("col_ready", {31'd0, fetch_ready}, 32'd0);
        step();
        chk("col_not_acc", {31'd0, instr_valid}, 32'd0);
        prog_we = 1'b0;
        #1;
        chk("col_ready2", {31'd0, fetch_ready}, 32'd1);
        step();
        fetch_req = 1'b0;
        chk("col_valid", {31'd0, instr_valid}, 32'd1);
        chk("col_instr", instr, 32'hDEADBEEF);

        // ---------------- 5a: reset mid-clear ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        chk("mc_ready", {31'd0, fetch_ready}, 32'd0);
        reset = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("mc_valid", {31'd0, instr_valid}, 32'd0);
        chk("mc_init", {31'd0, init_done}, 32'd0);
        run_clear("clr2");
        fetch("wiped3", 32'hC, NOP, 1'b0, 2'b00);

        // ---------------- 5b: reset with fetch in flight ----------------
        prog(6'd4, 32'h00500293, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        reset      = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("rif_valid", {31'd0, instr_valid}, 32'd0);
        chk("rif_instr", instr, NOP);
        step();
        chk("rif_valid2", {31'd0, instr_valid}, 32'd0);
        // A programming write late in the clear must be dropped.
        reset = 1'b0;
        for (int i = 0; i < DEPTH - 2; i++) step();
        prog_we   = 1'b1;
        prog_addr = 6'd9;
        prog_data = 32'h12345678;
        step();
        prog_we = 1'b0;
        chk("clr3_init_low", {31'd0, init_done}, 32'd0);
        step();
        chk("clr3_init_high", {31'd0, init_done}, 32'd1);
        fetch("drop9", 32'h24, NOP, 1'b0, 2'b00);
        fetch("wiped4", 32'h10, NOP, 1'b0, 2'b00);

`ifdef INSTR_MEM_PARITY_EN
        // ---------------- 6: parity ----------------
        prog(6'd5, 32'h00A00093, 1'b1);
        fetch("perr", 32'h14, NOP, 1'b1, 2'b11);
        fetch("perr_mis", 32'h15, NOP, 1'b1, 2'b01);
        prog(6'd5, 32'h00A00093, 1'b0);
        fetch("pok", 32'h14, 32'h00A00093, 1'b0, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised, synchronously-read instruction memory for the RISC-V single-cycle core, replacing the fixed 64-word asynchronous array. It adds:
- a request/valid fetch handshake with one-cycle latency;
- a word-write programming port for loading programs at run time;
- a post-reset clear sequencer that fills every word with NOP;
- fault reporting for misaligned and out-of-range fetches.

It sits between the PC register and the decoder.

## Interface

Parameters:
- `XLEN`, 32: instruction/data width in bits.
- `DEPTH`, 64: number of words; power of two, at least 2.
- `AW`, 32: byte-address width of `fetch_addr`.
- `NOP`, 32'h00000013: fill/fault instruction (`addi x0,x0,0`).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `fetch_req`  in  1: fetch request.
- `fetch_addr`  in  AW: byte address (PC).
- `fetch_ready`  out  1: a fetch is accepted this cycle if `fetch_req` is also high.
- `instr_valid`  out  1: one-cycle pulse; `instr`/`fetch_fault` are valid.
- `instr`  out  XLEN: fetched instruction.
- `fetch_fault`  out  1: accepted fetch faulted.
- `fault_cause`  out  2: 00 none, 01 misaligned, 10 out of range, 11 parity.
- `prog_we`  in  1: programming write strobe.
- `prog_addr`  in  log2(DEPTH): word index.
- `prog_data`  in  XLEN: word to write.
- `prog_perr_inject`  in  1: invert the stored parity on this write; ignored unless parity is enabled.
- `init_done`  out  1: clear sequence finished.

## Operation

FSM states:
- **CLEAR**: entered on `reset`. Counter `clr_idx` runs from 0 to DEPTH-1 and writes `NOP` to one word per cycle. After writing index DEPTH-1, go to READY.
- **READY**: `init_done`=1; fetches and programming are serviced. It is left only via `reset`.

Fetch:
- Accepted when `fetch_req && fetch_ready` at a rising edge.
- `fetch_ready` = (state==READY) && !`prog_we`. A programming write has priority and stalls fetch for that cycle.
- Word index = `fetch_addr[log2(DEPTH)+1:2]`.
- Fault checks, in priority order:
  1. `fetch_addr[1:0]`≠0 → cause 01.
  2. `fetch_addr` ≥ 4·DEPTH → cause 10.
  3. Parity mismatch → cause 11, only when parity is enabled.
- On any fault: `instr`=`NOP` and `fetch_fault`=1. The array is not otherwise affected.

Programming:
- A write with `prog_we`=1 in READY stores `prog_data` at `prog_addr` at the edge.
- `prog_we` during CLEAR is ignored and dropped.
- A fetch accepted in a later cycle returns the new data.

## Timing

Reset values, held through the edge where `reset`=1:
- `instr_valid`=0, `instr`=`NOP`, `fetch_fault`=0, `fault_cause`=00.
- `fetch_ready`=0, `init_done`=0, `clr_idx`=0.

Clear and readiness:
- With `reset` low from edge 0, CLEAR writes words 0..DEPTH-1 on edges 0..DEPTH-1.
- `init_done`/`fetch_ready` go high after edge DEPTH-1, so the first fetch can be accepted at edge DEPTH.

Fetch latency:
- A fetch accepted at edge N gives `instr_valid`=1 with its `instr`/`fetch_fault`/`fault_cause` after edge N, visible in cycle N+1.
- `instr_valid` deasserts after edge N+1 unless another fetch was accepted at N+1.
- Back-to-back fetches give one result per cycle.
- There is no output backpressure.

Outputs with no accepted fetch:
- `instr` holds its last value.
- `fetch_fault`/`fault_cause` return to 0 together with `instr_valid`.

Reset mid-operation (mid-clear or mid-stream):
- Aborts the operation, drops any in-flight result (`instr_valid`=0 next cycle) and restarts CLEAR from index 0.

## Configuration

`INSTR_MEM_PARITY_EN`
- **Defined**:
  - Each word stores XLEN+1 bits: data plus even parity computed on write (clear writes correct parity for `NOP`).
  - `prog_perr_inject`=1 inverts the stored parity bit.
  - A read whose recomputed parity mismatches returns `NOP` with cause 11, unless a higher-priority fault applies.
- **Undefined**:
  - Array is XLEN wide.
  - `prog_perr_inject` is unused.
  - Cause 11 is never produced.

## Test plan

1. **Clear sequence.** Reset 1 cycle, DEPTH=64.
   - `init_done` rises after edge 63.
   - Fetch 0x0, 0x4, 0xFC each return 0x00000013 with no fault.
2. **Program and stream.** Program word 3 = 0x01980 6B3 (`add x13,x16,x25`, 0x019806B3), then fetch 0xC at the next edge.
   - `instr_valid` appears 1 cycle later with 0x019806B3.
   - Four back-to-back fetches of 0x0–0xC yield 4 consecutive valid cycles.
3. **Faults.**
   - Fetch 0x6 → NOP, `fetch_fault`=1, cause 01.
   - Fetch 0x100 at DEPTH=64 → cause 10.
   - Fetch 0x102 → cause 01 (misalignment has priority).
4. **Write/fetch collision.** `prog_we`=1 and `fetch_req`=1 in the same cycle.
   - `fetch_ready`=0 and the fetch is not accepted.
   - The fetch is accepted in the next cycle and returns the newly written word.
5. **Reset mid-clear and mid-stream.**
   - Reset at `clr_idx`=20: `clr_idx` goes to 0 and `init_done` rises 64 cycles after release.
   - Reset with a fetch in flight: no `instr_valid` pulse.
6. **Parity, with `INSTR_MEM_PARITY_EN`.** Program word 5 = 0x00A00093 with `prog_perr_inject`=1, then fetch 0x14.
   - Returns NOP, cause 11.
   - After rewriting word 5 without inject, the fetch returns 0x00A00093 with no fault.
